// File: rtl/bht_update_ctrl.sv
// Branch history table update controller.
// Shares a single-read-port BHT between fetch predictions and execute-stage updates.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fetch_valid/ready fetch handshake; pred_taken is the prediction
//   res_valid/ready   resolve handshake for the oldest in-flight branch
//   res_taken         resolved outcome
//   flush             one-cycle pulse after a mispredict update
//   tbl_rd_idx/data   table read port (data combinational from idx)
//   tbl_wr_en/idx/data table write port
//   init_done         table initialisation complete
//   branch_cnt        resolved branch count (saturating)
//   mispred_cnt       mispredicted branch count (saturating)

module bht_update_ctrl #(
    parameter int         HIST_BITS = 2,
    parameter int         DEPTH     = 4,
    parameter logic [1:0] INIT_VAL  = 2'b01,
    parameter int         CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    output logic                 pred_taken,
    input  logic                 res_valid,
    input  logic                 res_taken,
    output logic                 res_ready,
    output logic                 flush,
    output logic [HIST_BITS-1:0] tbl_rd_idx,
    input  logic [1:0]           tbl_rd_data,
    output logic                 tbl_wr_en,
    output logic [HIST_BITS-1:0] tbl_wr_idx,
    output logic [1:0]           tbl_wr_data,
    output logic                 init_done,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] Q_MAX = (PW+1)'(DEPTH);
    localparam logic [HIST_BITS-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPD,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HIST_BITS-1:0] init_ptr;
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] q_idx [DEPTH];
    logic                 q_pred [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW:0]          count;
    logic                 res_q;

    logic                 q_full;
    logic                 q_empty;
    logic                 fetch_hs;
    logic                 res_hs;
    logic                 upd_mis;
    logic [HIST_BITS-1:0] head_idx;
    logic                 head_pred;
    logic [1:0]           upd_data;

    assign q_full    = (count == Q_MAX);
    assign q_empty   = (count == '0);
    assign head_idx  = q_idx[head];
    assign head_pred = q_pred[head];

    assign fetch_hs  = fetch_valid && fetch_ready;
    assign res_hs    = res_valid && res_ready;

    assign pred_taken = tbl_rd_data[1];
    assign init_done  = (state != INIT);

    // Saturating 2-bit counter step using the latched outcome.
    always_comb begin
        upd_data = tbl_rd_data;
        if (res_q) begin
            if (tbl_rd_data != 2'b11) begin
                upd_data = tbl_rd_data + 2'd1;
            end
        end else begin
            if (tbl_rd_data != 2'b00) begin
                upd_data = tbl_rd_data - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        res_ready   = 1'b0;
        flush       = 1'b0;
        tbl_rd_idx  = ghr;
        tbl_wr_en   = 1'b0;
        tbl_wr_idx  = init_ptr;
        tbl_wr_data = INIT_VAL;
        upd_mis     = 1'b0;

        unique case (state)
            INIT: begin
                tbl_wr_en = 1'b1;
                if (init_ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                fetch_ready = !q_full;
                res_ready   = !q_empty;
                if (res_valid && !q_empty) begin
                    state_nxt = UPD;
                end
            end
            UPD: begin
                tbl_rd_idx  = head_idx;
                tbl_wr_en   = 1'b1;
                tbl_wr_idx  = head_idx;
                tbl_wr_data = upd_data;
                upd_mis     = (head_pred != res_q);
                state_nxt   = upd_mis ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        // A reset cycle must never write the table or accept traffic.
        if (reset) begin
            fetch_ready = 1'b0;
            res_ready   = 1'b0;
            flush       = 1'b0;
            tbl_wr_en   = 1'b0;
        end
    end

    // Queue storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (fetch_hs) begin
            q_idx[tail]  <= ghr;
            q_pred[tail] <= tbl_rd_data[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr    <= '0;
            ghr         <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            res_q       <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (state == INIT) begin
                init_ptr <= init_ptr + HIST_BITS'(1);
            end

            if (res_hs) begin
                res_q <= res_taken;
            end

            if (fetch_hs) begin
                tail  <= tail + PW'(1);
                count <= count + (PW+1)'(1);
            end

            // Fetch is never accepted in UPD, so these cannot collide.
            if (state == UPD) begin
                ghr <= {ghr[HIST_BITS-2:0], res_q};
                if (branch_cnt != '1) begin
                    branch_cnt <= branch_cnt + CNT_W'(1);
                end
                if (upd_mis) begin
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                    if (mispred_cnt != '1) begin
                        mispred_cnt <= mispred_cnt + CNT_W'(1);
                    end
                end else begin
                    head  <= head + PW'(1);
                    count <= count - (PW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Testbench for bht_update_ctrl.
// Random fetch/resolve traffic against a table model and an in-order prediction queue.

module tb_bht_update_ctrl;

    localparam int HB   = 2;
    localparam int DP   = 4;
    localparam int CW   = 8;
    localparam int TBL  = 1 << HB;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_valid = 1'b0;
    logic          fetch_ready;
    logic          pred_taken;
    logic          res_valid = 1'b0;
    logic          res_taken = 1'b0;
    logic          res_ready;
    logic          flush;
    logic [HB-1:0] tbl_rd_idx;
    logic [1:0]    tbl_rd_data;
    logic          tbl_wr_en;
    logic [HB-1:0] tbl_wr_idx;
    logic [1:0]    tbl_wr_data;
    logic          init_done;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    always #5 clk = ~clk;

    bht_update_ctrl #(
        .HIST_BITS(HB),
        .DEPTH(DP),
        .INIT_VAL(2'b01),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .pred_taken(pred_taken),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_ready(res_ready),
        .flush(flush),
        .tbl_rd_idx(tbl_rd_idx),
        .tbl_rd_data(tbl_rd_data),
        .tbl_wr_en(tbl_wr_en),
        .tbl_wr_idx(tbl_wr_idx),
        .tbl_wr_data(tbl_wr_data),
        .init_done(init_done),
        .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    // Table memory seen by the DUT.
    logic [1:0] mem [TBL];
    assign tbl_rd_data = mem[tbl_rd_idx];
    always @(posedge clk) begin
        if (tbl_wr_en) mem[tbl_wr_idx] <= tbl_wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int data;
        bit mis;
        int due;
    } wr_t;

    wr_t exp_wr[$];
    bit  exp_pred[$];
    int  total = 0;
    int  bad = 0;

    // Reference model state.
    int ref_tbl[TBL];
    int ghr_m;
    int mq_idx[$];
    bit mq_pred[$];
    int busy;
    int init_left;
    int bcnt;
    int mcnt;
    int bias;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        total++;
        bad++;
        $display("FAIL %s got=none want=event cyc=%0d", name, cyc);
    endtask

    task automatic step(input bit rst, input bit quiet, output bit did_res);
        bit fh;
        bit rh;
        bit p;
        bit mis;
        int idx;
        int v;
        int nd;
        did_res = 1'b0;
        @(negedge clk);
        #1;
        reset       = rst;
        fetch_valid = !rst && !quiet && ($urandom_range(0, 3) != 0);
        res_valid   = !rst && !quiet && ($urandom_range(0, 99) < 45);
        res_taken   = ($urandom_range(0, 99) < bias);
        #1;
        if (rst) begin
            exp_wr.delete();
            exp_pred.delete();
            mq_idx.delete();
            mq_pred.delete();
            for (int i = 0; i < TBL; i++) begin
                ref_tbl[i] = 1;
                exp_wr.push_back('{i, 1, 1'b0, cyc + 1 + i});
            end
            ghr_m     = 0;
            busy      = 0;
            init_left = TBL;
            bcnt      = 0;
            mcnt      = 0;
            chk("rst_fetch_ready", int'(fetch_ready), 0);
            chk("rst_res_ready", int'(res_ready), 0);
            return;
        end

        chk("fetch_ready", int'(fetch_ready),
            int'(init_left == 0 && busy == 0 && mq_idx.size() < DP));
        chk("res_ready", int'(res_ready),
            int'(init_left == 0 && busy == 0 && mq_idx.size() > 0));
        chk("init_done", int'(init_done), int'(init_left == 0));
        if (init_left == 0 && busy == 0) begin
            chk("branch_cnt", int'(branch_cnt), bcnt);
            chk("mispred_cnt", int'(mispred_cnt), mcnt);
        end

        fh = fetch_valid && fetch_ready;
        rh = res_valid && res_ready && (mq_idx.size() > 0);

        // Fetch reads the table and history before a same-cycle resolve applies.
        if (fh) begin
            p = (ref_tbl[ghr_m] >= 2);
            exp_pred.push_back(p);
            mq_idx.push_back(ghr_m);
            mq_pred.push_back(p);
        end

        if (init_left > 0) init_left--;
        else if (busy > 0) busy--;

        if (rh) begin
            idx = mq_idx.pop_front();
            p   = mq_pred.pop_front();
            v   = ref_tbl[idx];
            if (res_taken) nd = (v == 3) ? 3 : v + 1;
            else nd = (v == 0) ? 0 : v - 1;
            mis = (p != res_taken);
            exp_wr.push_back('{idx, nd, mis, cyc + 1});
            ref_tbl[idx] = nd;
            ghr_m = ((ghr_m << 1) | int'(res_taken)) % TBL;
            if (bcnt < CMAX) bcnt++;
            if (mis) begin
                if (mcnt < CMAX) mcnt++;
                mq_idx.delete();
                mq_pred.delete();
            end
            busy    = mis ? 2 : 1;
            did_res = 1'b1;
        end
    endtask

    // Monitor: compares every table write, flush and prediction.
    bit flush_exp = 1'b0;
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                chk("wr_en_in_reset", int'(tbl_wr_en), 0);
                chk("flush_in_reset", int'(flush), 0);
                flush_exp = 1'b0;
            end else begin
                chk("flush", int'(flush), int'(flush_exp));
                flush_exp = 1'b0;
                if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
                    w = exp_wr.pop_front();
                    chk("wr_en", int'(tbl_wr_en), 1);
                    chk("wr_idx", int'(tbl_wr_idx), w.idx);
                    chk("wr_data", int'(tbl_wr_data), w.data);
                    flush_exp = w.mis;
                end else begin
                    chk("wr_en_quiet", int'(tbl_wr_en), 0);
                end
                if (fetch_valid && fetch_ready) begin
                    if (exp_pred.size() == 0) miss("pred_queue");
                    else chk("pred_taken", int'(pred_taken), int'(exp_pred.pop_front()));
                end
            end
        end
    end

    initial begin
        bit d;
        bit found;
        bias = 80;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0, d);

        // Reset landing on the UPD cycle.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) step(1'b0, 1'b0, found);
        if (!found) miss("resolve_before_reset");
        step(1'b1, 1'b0, d);

        bias = 50;
        for (int k = 0; k < 3000; k++) step(1'b0, 1'b0, d);

        bias = 15;
        for (int k = 0; k < 400; k++) step(1'b0, 1'b0, d);

        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, d);
        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_pred_left", exp_pred.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
